redmule_tile_sequencer: RTL and testbench
=========================================

REDMULE_TILE_SEQUENCER -- requirements
Module: redmule_tile_sequencer

Interface
REQ-001 SHALL have parameter ARRAY_WIDTH, default 12, meaning engine rows per tile.
REQ-002 SHALL have parameter ARRAY_HEIGHT, default 4, meaning engine columns.
REQ-003 SHALL have parameter PIPE_REGS, default 3, meaning CE pipeline depth; W tile width = (PIPE_REGS+1)*ARRAY_HEIGHT.
REQ-004 SHALL have parameter ITER_W, default 16, meaning iteration-counter width.
REQ-005 SHALL have port clk_i, input, 1, the single clock; reset is synchronous and active-high.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start_i, input, 1, job start pulse.
REQ-008 SHALL have port abort_i, input, 1, job cancel.
REQ-009 SHALL have port m_iters_i, input, ITER_W, X-row tile count (X_ITERS[31:16]).
REQ-010 SHALL have port n_iters_i, input, ITER_W, X-col/W-row tile count (X_ITERS[15:0]).
REQ-011 SHALL have port k_iters_i, input, ITER_W, W-col tile count (W_ITERS[15:0]).
REQ-012 SHALL have port leftovers_i, input, 32, LEFTOVERS register layout.
REQ-013 SHALL have ports tile_valid_o (output, 1) and tile_ready_i (input, 1), the tile handshake.
REQ-014 SHALL have ports tile_m_o, tile_n_o, tile_k_o, output, ITER_W each, tile indices.
REQ-015 SHALL have ports tile_last_n_o and tile_first_n_o, output, 1 each.
REQ-016 SHALL have ports x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o, output, 8 each; 0 = full tile.
REQ-017 SHALL have ports z_store_valid_o (output, 1) and z_store_ready_i (input, 1), the store handshake.
REQ-018 SHALL have ports busy_o, done_o and cfg_err_o, output, 1 each.
REQ-019 SHALL have port perf_stall_o, output, 32, tile-backpressure cycle count.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, STORE, FINISH.
REQ-021 SHALL, in IDLE on start_i=1, latch all config inputs, clear m/k/n counters and go to ISSUE, with tile_valid_o high on the next cycle.
REQ-022 SHALL, if any latched iteration count is 0, go from IDLE to FINISH instead, pulsing cfg_err_o together with done_o and issuing no tile.
REQ-023 SHALL iterate n innermost, k middle, m outermost; indices run 0..count-1.
REQ-024 SHALL hold tile outputs stable while tile_valid_o=1 and tile_ready_i=0, and advance only on valid&ready.
REQ-025 SHALL set tile_first_n_o when n==0 and tile_last_n_o when n==n_iters-1.
REQ-026 SHALL drive x_rows_lftovr_o=leftovers[31:24] only when m==m_iters-1, x_cols_lftovr_o=[23:16] and w_rows_lftovr_o=[15:8] only when n==n_iters-1, and w_cols_lftovr_o=[7:0] only when k==k_iters-1; otherwise 0.
REQ-027 SHALL go ISSUE->STORE on an accepted tile with tile_last_n_o=1, deasserting tile_valid_o and asserting z_store_valid_o on the next cycle.
REQ-028 SHALL go STORE->ISSUE on z_store_ready_i=1 if (m,k) is not final, else STORE->FINISH.
REQ-029 SHALL pulse done_o for exactly one cycle in FINISH, then return to IDLE.
REQ-030 SHALL hold busy_o=1 in every state except IDLE.
REQ-031 SHALL ignore start_i when not in IDLE.
REQ-032 SHALL, on abort_i=1 in any state, go to IDLE on the next cycle, drop all valids, and give no done_o; abort_i takes priority over start_i and all handshakes.
REQ-033 SHALL use counter widths of ITER_W; counts up to 2^ITER_W-1 SHALL work without wrap.

Reset
REQ-034 SHALL, on rst_i=1 at a clk_i edge, enter IDLE and zero all outputs, counters and latched config.
REQ-035 SHALL, on reset mid-job, abandon the job with no done_o.

Configuration
REQ-036 SHALL, with REDMULE_SEQ_PERF_EN defined, make perf_stall_o count cycles with tile_valid_o=1 and tile_ready_i=0, cleared on an accepted start_i, saturating at 2^32-1.
REQ-037 SHALL, without REDMULE_SEQ_PERF_EN, tie perf_stall_o to 0 and instantiate no counter.

Structure
REQ-038 SHALL place the state enum, the leftover bit-field offsets and a tile_req_t struct (indices, flags, leftovers) in redmule_pkg.
REQ-039 SHALL use one sub-module, redmule_iter_counter (an enable/clear/count counter with a last flag), instantiated three times for m, k and n.

Verification
REQ-040 SHALL cover m=1, k=1, n=3, ready always high, leftovers=0x05030201: 3 tiles, n=0,1,2, then a store, then done 5 cycles after start; only the n=2 tile carries x_cols=3 and w_rows=2.
REQ-041 SHALL cover m=2, k=2, n=1: 4 tiles, each followed by a store, in (m,k) order (0,0),(0,1),(1,0),(1,1), then done_o once.
REQ-042 SHALL cover tile_ready_i low for 4 cycles on tile 0: outputs stable, then perf_stall_o=4 with REDMULE_SEQ_PERF_EN and 0 without.
REQ-043 SHALL cover n_iters=0: no tile_valid_o; done_o and cfg_err_o pulse together; busy_o returns low.
REQ-044 SHALL cover abort_i during STORE with z_store_ready_i=0: IDLE the next cycle, all valids low, no done_o; a new start_i then runs normally.
REQ-045 SHALL cover start_i while busy and rst_i mid-ISSUE: start_i is ignored; reset zeroes every output the following cycle.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE tile sequencer: FSM states, LEFTOVERS field offsets
// and the per-tile request record.
package redmule_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StStore,
    StFinish
  } seq_state_e;

  // LEFTOVERS register layout, one byte per field.
  localparam int unsigned LftW     = 8;
  localparam int unsigned XRowsLsb = 24;
  localparam int unsigned XColsLsb = 16;
  localparam int unsigned WRowsLsb = 8;
  localparam int unsigned WColsLsb = 0;

  // Widest iteration index the request record can carry.
  localparam int unsigned IdxW = 32;

  typedef struct packed {
    logic [IdxW-1:0] m;
    logic [IdxW-1:0] n;
    logic [IdxW-1:0] k;
    logic            first_n;
    logic            last_n;
    logic [LftW-1:0] x_rows;
    logic [LftW-1:0] x_cols;
    logic [LftW-1:0] w_rows;
    logic [LftW-1:0] w_cols;
  } tile_req_t;

  function automatic logic [LftW-1:0] lftovr_field(input logic [31:0] lft,
                                                   input int unsigned lsb,
                                                   input logic sel);
    return sel ? lft[lsb +: LftW] : '0;
  endfunction

endpackage

// File: rtl/redmule_iter_counter.sv
// Wrapping iteration counter: runs 0..count-1, flags the last index, clears on demand.
module redmule_iter_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] count_i,
  output logic [WIDTH-1:0] value_o,
  output logic             last_o
);

  logic [WIDTH-1:0] value_d, value_q;

  // A zero count never matches, since the value never reaches all-ones.
  assign last_o  = (value_q == (count_i - WIDTH'(1)));
  assign value_o = value_q;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (en_i) begin
      value_d = last_o ? '0 : value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/redmule_tile_sequencer.sv
// Walks the m/k/n tile space of a RedMulE job, issuing tiles and Z stores.
// Optional stall counter enabled by defining REDMULE_SEQ_PERF_EN.
module redmule_tile_sequencer
  import redmule_pkg::*;
#(
  parameter int unsigned ARRAY_WIDTH  = 12,
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned PIPE_REGS    = 3,
  parameter int unsigned ITER_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ITER_W-1:0] m_iters_i,
  input  logic [ITER_W-1:0] n_iters_i,
  input  logic [ITER_W-1:0] k_iters_i,
  input  logic [31:0]       leftovers_i,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [ITER_W-1:0] tile_m_o,
  output logic [ITER_W-1:0] tile_n_o,
  output logic [ITER_W-1:0] tile_k_o,
  output logic              tile_last_n_o,
  output logic              tile_first_n_o,
  output logic [7:0]        x_rows_lftovr_o,
  output logic [7:0]        x_cols_lftovr_o,
  output logic [7:0]        w_rows_lftovr_o,
  output logic [7:0]        w_cols_lftovr_o,
  output logic              z_store_valid_o,
  input  logic              z_store_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cfg_err_o,
  output logic [31:0]       perf_stall_o
);

  localparam int unsigned TileW = (PIPE_REGS + 1) * ARRAY_HEIGHT;

  // Tile dimensions must be expressible in the 8-bit leftover fields.
  if (ARRAY_WIDTH > 255 || TileW > 255 || ITER_W > IdxW) begin : g_bad_cfg
    $error("redmule_tile_sequencer: unsupported parameter combination");
  end

  seq_state_e state_d, state_q;

  logic [ITER_W-1:0] m_iters_q, n_iters_q, k_iters_q;
  logic [31:0]       lft_q;
  logic              cfg_err_q;

  logic [ITER_W-1:0] m_val, n_val, k_val;
  logic              m_last, n_last, k_last;

  logic cfg_zero, start_acc, tile_acc, store_acc, cnt_clr;
  tile_req_t tile_req;

  assign cfg_zero  = (m_iters_i == '0) || (n_iters_i == '0) || (k_iters_i == '0);
  assign start_acc = (state_q == StIdle) && start_i && !abort_i;
  assign tile_acc  = (state_q == StIssue) && tile_ready_i && !abort_i;
  assign store_acc = (state_q == StStore) && z_store_ready_i && !abort_i;
  assign cnt_clr   = start_acc || abort_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      m_iters_q <= '0;
      n_iters_q <= '0;
      k_iters_q <= '0;
      lft_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        m_iters_q <= m_iters_i;
        n_iters_q <= n_iters_i;
        k_iters_q <= k_iters_i;
        lft_q     <= leftovers_i;
        cfg_err_q <= cfg_zero;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = cfg_zero ? StFinish : StIssue;
      StIssue:  if (tile_ready_i && n_last) state_d = StStore;
      StStore:  if (z_store_ready_i) state_d = (m_last && k_last) ? StFinish : StIssue;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort_i) state_d = StIdle;
  end

  // n innermost, k advances per store, m when k wraps.
  redmule_iter_counter #(.WIDTH(ITER_W)) u_cnt_n (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (tile_acc),
    .count_i (n_iters_q),
    .value_o (n_val),
    .last_o  (n_last)
  );

  redmule_iter_counter #(.WIDTH(ITER_W)) u_cnt_k (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (store_acc),
    .count_i (k_iters_q),
    .value_o (k_val),
    .last_o  (k_last)
  );

  redmule_iter_counter #(.WIDTH(ITER_W)) u_cnt_m (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (cnt_clr),
    .en_i    (store_acc && k_last),
    .count_i (m_iters_q),
    .value_o (m_val),
    .last_o  (m_last)
  );

  assign tile_valid_o    = (state_q == StIssue);
  assign z_store_valid_o = (state_q == StStore);
  assign busy_o          = (state_q != StIdle);
  assign done_o          = (state_q == StFinish);
  assign cfg_err_o       = (state_q == StFinish) && cfg_err_q;

  // Tile fields read as zero whenever no tile is offered.
  always_comb begin
    tile_req = '0;
    if (tile_valid_o) begin
      tile_req.m       = IdxW'(m_val);
      tile_req.n       = IdxW'(n_val);
      tile_req.k       = IdxW'(k_val);
      tile_req.first_n = (n_val == '0);
      tile_req.last_n  = n_last;
      tile_req.x_rows  = lftovr_field(lft_q, XRowsLsb, m_last);
      tile_req.x_cols  = lftovr_field(lft_q, XColsLsb, n_last);
      tile_req.w_rows  = lftovr_field(lft_q, WRowsLsb, n_last);
      tile_req.w_cols  = lftovr_field(lft_q, WColsLsb, k_last);
    end
  end

  assign tile_m_o        = tile_req.m[ITER_W-1:0];
  assign tile_n_o        = tile_req.n[ITER_W-1:0];
  assign tile_k_o        = tile_req.k[ITER_W-1:0];
  assign tile_first_n_o  = tile_req.first_n;
  assign tile_last_n_o   = tile_req.last_n;
  assign x_rows_lftovr_o = tile_req.x_rows;
  assign x_cols_lftovr_o = tile_req.x_cols;
  assign w_rows_lftovr_o = tile_req.w_rows;
  assign w_cols_lftovr_o = tile_req.w_cols;

`ifdef REDMULE_SEQ_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (tile_valid_o && !tile_ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_o = stall_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// Directed bench for redmule_tile_sequencer: table of jobs plus hand-written corner sequences.
module tb_redmule_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] m_iters, n_iters, k_iters;
  logic [31:0] leftovers;
  logic        tile_valid, tile_ready;
  logic [15:0] tile_m, tile_n, tile_k;
  logic        tile_last_n, tile_first_n;
  logic [7:0]  x_rows, x_cols, w_rows, w_cols;
  logic        z_store_valid, z_store_ready;
  logic        busy, done, cfg_err;
  logic [31:0] perf_stall;

  always #5 clk = ~clk;

  redmule_tile_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .abort_i         (abort),
    .m_iters_i       (m_iters),
    .n_iters_i       (n_iters),
    .k_iters_i       (k_iters),
    .leftovers_i     (leftovers),
    .tile_valid_o    (tile_valid),
    .tile_ready_i    (tile_ready),
    .tile_m_o        (tile_m),
    .tile_n_o        (tile_n),
    .tile_k_o        (tile_k),
    .tile_last_n_o   (tile_last_n),
    .tile_first_n_o  (tile_first_n),
    .x_rows_lftovr_o (x_rows),
    .x_cols_lftovr_o (x_cols),
    .w_rows_lftovr_o (w_rows),
    .w_cols_lftovr_o (w_cols),
    .z_store_valid_o (z_store_valid),
    .z_store_ready_i (z_store_ready),
    .busy_o          (busy),
    .done_o          (done),
    .cfg_err_o       (cfg_err),
    .perf_stall_o    (perf_stall)
  );

  typedef struct {
    logic [15:0] m;
    logic [15:0] k;
    logic [15:0] n;
    logic [31:0] lft;
    int          tiles;
    int          stores;
    int          done_cyc;
    logic        err;
  } job_t;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

`ifdef REDMULE_SEQ_PERF_EN
  localparam logic [31:0] ExpStall = 32'd4;
`else
  localparam logic [31:0] ExpStall = 32'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] ored;
    ored = 32'(tile_valid) | 32'(tile_m) | 32'(tile_n) | 32'(tile_k) | 32'(tile_last_n)
         | 32'(tile_first_n) | 32'(x_rows) | 32'(x_cols) | 32'(w_rows) | 32'(w_cols)
         | 32'(z_store_valid) | 32'(busy) | 32'(done) | 32'(cfg_err);
    check({tag, "_outputs_or"}, ored, 32'd0);
    check({tag, "_perf"}, perf_stall, 32'd0);
  endtask

  // Steps until done_o is seen; steps = -1 if the budget runs out.
  task automatic wait_done(input int limit, output int steps);
    steps = -1;
    for (int i = 0; i <= limit; i++) begin
      if (done === 1'b1) begin
        steps = i;
        break;
      end
      step();
    end
  endtask

  task automatic run_job(input job_t j);
    int t, s, cyc, nd, kd, mm, kk, nn;
    bit got_done;
    nd = (j.n == 0) ? 1 : int'(j.n);
    kd = (j.k == 0) ? 1 : int'(j.k);
    t = 0;
    s = 0;
    got_done = 0;
    m_iters = j.m;
    n_iters = j.n;
    k_iters = j.k;
    leftovers = j.lft;
    tile_ready = 1'b1;
    z_store_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (cyc = 1; cyc <= 300; cyc++) begin
      if (tile_valid === 1'b1) begin
        nn = t % nd;
        kk = (t / nd) % kd;
        mm = t / (nd * kd);
        check("tile_m", 32'(tile_m), 32'(mm));
        check("tile_k", 32'(tile_k), 32'(kk));
        check("tile_n", 32'(tile_n), 32'(nn));
        check("tile_first_n", 32'(tile_first_n), 32'(nn == 0));
        check("tile_last_n", 32'(tile_last_n), 32'(nn == nd - 1));
        check("x_rows", 32'(x_rows), (mm == int'(j.m) - 1) ? 32'(j.lft[31:24]) : 32'd0);
        check("x_cols", 32'(x_cols), (nn == nd - 1) ? 32'(j.lft[23:16]) : 32'd0);
        check("w_rows", 32'(w_rows), (nn == nd - 1) ? 32'(j.lft[15:8]) : 32'd0);
        check("w_cols", 32'(w_cols), (kk == kd - 1) ? 32'(j.lft[7:0]) : 32'd0);
        t++;
      end
      if (z_store_valid === 1'b1) begin
        check("store_after_tiles", 32'(t), 32'((s + 1) * nd));
        check("store_tile_valid", 32'(tile_valid), 32'd0);
        s++;
      end
      if (done === 1'b1) begin
        got_done = 1;
        check("done_cycle", 32'(cyc), 32'(j.done_cyc));
        check("done_cfg_err", 32'(cfg_err), 32'(j.err));
        check("tile_count", 32'(t), 32'(j.tiles));
        check("store_count", 32'(s), 32'(j.stores));
        break;
      end
      step();
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    step();
    check("post_done_busy", 32'(busy), 32'd0);
    check("post_done_done", 32'(done), 32'd0);
  endtask

  job_t jobs[6];

  initial begin
    int st;
    jobs[0] = '{m: 16'd1, k: 16'd1, n: 16'd3, lft: 32'h0503_0201,
                tiles: 3, stores: 1, done_cyc: 5, err: 1'b0};
    jobs[1] = '{m: 16'd2, k: 16'd2, n: 16'd1, lft: 32'h0A0B_0C0D,
                tiles: 4, stores: 4, done_cyc: 9, err: 1'b0};
    jobs[2] = '{m: 16'd2, k: 16'd1, n: 16'd2, lft: 32'h1122_3344,
                tiles: 4, stores: 2, done_cyc: 7, err: 1'b0};
    jobs[3] = '{m: 16'd1, k: 16'd1, n: 16'd0, lft: 32'h0503_0201,
                tiles: 0, stores: 0, done_cyc: 1, err: 1'b1};
    jobs[4] = '{m: 16'd0, k: 16'd3, n: 16'd3, lft: 32'h0000_0000,
                tiles: 0, stores: 0, done_cyc: 1, err: 1'b1};
    jobs[5] = '{m: 16'd1, k: 16'd3, n: 16'd2, lft: 32'h0000_0000,
                tiles: 6, stores: 3, done_cyc: 10, err: 1'b0};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    m_iters = '0;
    n_iters = '0;
    k_iters = '0;
    leftovers = '0;
    tile_ready = 1'b0;
    z_store_ready = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Backpressure on tile 0 for four cycles.
    m_iters = 16'd1; k_iters = 16'd1; n_iters = 16'd2; leftovers = 32'h0;
    tile_ready = 1'b0;
    z_store_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(tile_valid), 32'd1);
      check("stall_tile_n", 32'(tile_n), 32'd0);
      check("stall_first", 32'(tile_first_n), 32'd1);
      check("stall_last", 32'(tile_last_n), 32'd0);
      step();
    end
    check("stall_perf", perf_stall, ExpStall);
    tile_ready = 1'b1;
    wait_done(20, st);
    check("stall_done_steps", 32'(st), 32'd3);
    check("stall_perf_end", perf_stall, ExpStall);
    step();

    // Abort while the store is back-pressured.
    m_iters = 16'd1; k_iters = 16'd1; n_iters = 16'd1; leftovers = 32'h0;
    tile_ready = 1'b1;
    z_store_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("abort_store_valid", 32'(z_store_valid), 32'd1);
    check("abort_store_no_tile", 32'(tile_valid), 32'd0);
    step();
    check("abort_store_held", 32'(z_store_valid), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    z_store_ready = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valids", {30'd0, tile_valid, z_store_valid}, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_done", 32'(done | busy), 32'd0);
    end
    run_job(jobs[0]);

    // Start while busy is ignored; reset mid-ISSUE abandons the job.
    m_iters = 16'd1; k_iters = 16'd1; n_iters = 16'd4; leftovers = 32'hFFFF_FFFF;
    tile_ready = 1'b0;
    start = 1'b1;
    step();
    n_iters = 16'd1;
    step();
    start = 1'b0;
    check("busy_start_busy", 32'(busy), 32'd1);
    check("busy_start_tile_n", 32'(tile_n), 32'd0);
    tile_ready = 1'b1;
    step();
    check("busy_start_advance", 32'(tile_n), 32'd1);
    check("busy_start_last", 32'(tile_last_n), 32'd0);
    check("busy_start_first", 32'(tile_first_n), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midjob_reset");
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_no_done", 32'(done | busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
